// File: rtl/hazard_unit_pkg.sv
// Shared hazard-control codes, FSM states and stage-control bundle
// for the hazard unit and the stage registers it drives.
package hazard_unit_pkg;

  localparam int HAZD_CTL_WIDTH = 2;
  localparam int REG_IDX_W      = 5;

  typedef logic [HAZD_CTL_WIDTH-1:0] hazd_ctl_t;

  localparam hazd_ctl_t HAZD_CTL_NORMAL = 2'b00;
  localparam hazd_ctl_t HAZD_CTL_RETRY  = 2'b01;
  localparam hazd_ctl_t HAZD_CTL_NO_OP  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_PAUSE    = 2'd2
  } hz_state_t;

  typedef struct packed {
    hazd_ctl_t pc;
    hazd_ctl_t if_id;
    hazd_ctl_t id_ex;
    hazd_ctl_t ex_mem;
    hazd_ctl_t mem_wb;
  } hz_set_t;

  function automatic hz_set_t hz_normal();
    hz_set_t s;
    s.pc     = HAZD_CTL_NORMAL;
    s.if_id  = HAZD_CTL_NORMAL;
    s.id_ex  = HAZD_CTL_NORMAL;
    s.ex_mem = HAZD_CTL_NORMAL;
    s.mem_wb = HAZD_CTL_NORMAL;
    return s;
  endfunction

  // mem_wb gets a bubble so a held instruction never writes back twice
  function automatic hz_set_t hz_freeze();
    hz_set_t s;
    s.pc     = HAZD_CTL_RETRY;
    s.if_id  = HAZD_CTL_RETRY;
    s.id_ex  = HAZD_CTL_RETRY;
    s.ex_mem = HAZD_CTL_RETRY;
    s.mem_wb = HAZD_CTL_NO_OP;
    return s;
  endfunction

  function automatic hz_set_t hz_drop();
    hz_set_t s;
    s        = hz_freeze();
    s.ex_mem = HAZD_CTL_NORMAL;
    return s;
  endfunction

  function automatic hz_set_t hz_load_use();
    hz_set_t s;
    s.pc     = HAZD_CTL_RETRY;
    s.if_id  = HAZD_CTL_RETRY;
    s.id_ex  = HAZD_CTL_NO_OP;
    s.ex_mem = HAZD_CTL_NORMAL;
    s.mem_wb = HAZD_CTL_NORMAL;
    return s;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-control bus from the hazard unit to the fetch block and
// the four pipeline stage registers.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  hazd_ctl_t pc_hazard;
  hazd_ctl_t if_id_hazard;
  hazd_ctl_t id_ex_hazard;
  hazd_ctl_t ex_mem_hazard;
  hazd_ctl_t mem_wb_hazard;
  logic      ignore_no_op;

  modport master (
    output pc_hazard,
    output if_id_hazard,
    output id_ex_hazard,
    output ex_mem_hazard,
    output mem_wb_hazard,
    output ignore_no_op
  );

  modport slave (
    input pc_hazard,
    input if_id_hazard,
    input id_ex_hazard,
    input ex_mem_hazard,
    input mem_wb_hazard,
    input ignore_no_op
  );

endinterface

// File: rtl/hazard_unit_load_use_detect.sv
// Combinational load-use comparator between the ID consumer and
// the EX load.
module load_use_detect
  import hazard_unit_pkg::*;
(
  input  logic                 id_no_op,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_no_op,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_dest,
  output logic                 hazard
);

  logic producer;
  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign producer = ex_mem_read & ~ex_no_op & ~id_no_op
                  & (ex_dest != '0);

  assign rs_hit = id_uses_rs & (id_rs == ex_dest);
  assign rt_hit = id_uses_rt & (id_rt == ex_dest);

  assign hazard = producer & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, slow-memory freeze
// with timeout, external pause and a saturating stall counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_no_op,
  input  logic [REG_IDX_W-1:0]   id_rs,
  input  logic [REG_IDX_W-1:0]   id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   ex_no_op,
  input  logic                   ex_mem_read,
  input  logic [REG_IDX_W-1:0]   ex_dest,
  input  logic                   mem_req,
  input  logic                   mem_ack,
  input  logic                   pause_req,
  hazard_unit_if.master          hz,
  output logic                   paused,
  output logic                   mem_timeout,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT =
    TIMEOUT_W'(MEM_TIMEOUT);

  hz_state_t            state_q;
  hz_state_t            state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;
  hz_set_t              ctl;
  logic                 load_use;
  logic                 tmo_hit;
  logic                 prev_retry_q;
  logic                 stalling;

  load_use_detect u_lud (
    .id_no_op    (id_no_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_no_op    (ex_no_op),
    .ex_mem_read (ex_mem_read),
    .ex_dest     (ex_dest),
    .hazard      (load_use)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = hz_normal();
    tmo_hit = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (mem_req & ~mem_ack) begin
          ctl     = hz_freeze();
          cnt_d   = '0;
          state_d = ST_MEM_WAIT;
        end else begin
          if (load_use)
            ctl = hz_load_use();
          if (pause_req)
            state_d = ST_PAUSE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = pause_req ? ST_PAUSE : ST_RUN;
        end else if (cnt_q == TMO_LIMIT) begin
          // give up on the device: let ex_mem move past the access
          ctl     = hz_drop();
          tmo_hit = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          ctl   = hz_freeze();
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        ctl = hz_freeze();
        if (!pause_req)
          state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    if (rst)
      ctl = hz_normal();
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stalling = (ctl.pc != HAZD_CTL_NORMAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_retry_q <= 1'b0;
      mem_timeout  <= 1'b0;
      stall_count  <= '0;
    end else begin
      prev_retry_q <= (ctl.if_id == HAZD_CTL_RETRY);
      mem_timeout  <= tmo_hit;
      if (stalling && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign hz.pc_hazard     = ctl.pc;
  assign hz.if_id_hazard  = ctl.if_id;
  assign hz.id_ex_hazard  = ctl.id_ex;
  assign hz.ex_mem_hazard = ctl.ex_mem;
  assign hz.mem_wb_hazard = ctl.mem_wb;

  // IF refetches the held slot once the stall lifts; its bubble flag is stale
  assign hz.ignore_no_op = (ctl.if_id == HAZD_CTL_NORMAL)
                         & prev_retry_q;

  assign paused = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus a
// randomized run against a behavioural model.
module tb_hazard_unit;

  localparam int TMO = 4;
  localparam int SCW = 6;
  localparam int SAT = (1 << SCW) - 1;
  localparam int N = 0;
  localparam int R = 1;
  localparam int B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_no_op = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic id_uses_rs = 1'b0;
  logic id_uses_rt = 1'b0;
  logic ex_no_op = 1'b0;
  logic ex_mem_read = 1'b0;
  logic [4:0] ex_dest = '0;
  logic mem_req = 1'b0;
  logic mem_ack = 1'b0;
  logic pause_req = 1'b0;
  logic paused;
  logic mem_timeout;
  logic [SCW-1:0] stall_count;

  hazard_unit_if hz ();

  hazard_unit #(
    .MEM_TIMEOUT (TMO),
    .TIMEOUT_W   (8),
    .STALL_CNT_W (SCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_no_op    (id_no_op),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_no_op    (ex_no_op),
    .ex_mem_read (ex_mem_read),
    .ex_dest     (ex_dest),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pause_req   (pause_req),
    .hz          (hz),
    .paused      (paused),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: 0 running, 1 waiting on memory, 2 paused
  int m_mode = 0;
  int m_wait = 0;
  int m_stalls = 0;
  bit m_prev_retry = 1'b0;
  bit m_tmo = 1'b0;

  function automatic bit lu();
    bit dep;
    dep = (id_uses_rs && id_rs == ex_dest)
       || (id_uses_rt && id_rt == ex_dest);
    return ex_mem_read && !ex_no_op && !id_no_op
        && ex_dest != 0 && dep;
  endfunction

  // fetch is held whenever the pipeline cannot advance freely
  function automatic bit stalling();
    if (rst) return 1'b0;
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1) return !mem_ack;
    return (mem_req && !mem_ack) || lu();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_wait <= 0;
      m_stalls <= 0;
      m_prev_retry <= 1'b0;
      m_tmo <= 1'b0;
    end else begin
      m_prev_retry <= stalling();
      if (stalling() && m_stalls < SAT)
        m_stalls <= m_stalls + 1;
      m_tmo <= (m_mode == 1 && !mem_ack && m_wait == TMO);
      case (m_mode)
        0: if (mem_req && !mem_ack) begin
             m_mode <= 1;
             m_wait <= 0;
           end else if (pause_req) m_mode <= 2;
        1: if (mem_ack) begin
             m_wait <= 0;
             m_mode <= pause_req ? 2 : 0;
           end else if (m_wait == TMO) begin
             m_wait <= 0;
             m_mode <= 0;
           end else m_wait <= m_wait + 1;
        default: if (!pause_req) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    int e_pc, e_ifid, e_idex, e_exmem, e_memwb, e_ign;
    e_pc = N; e_ifid = N; e_idex = N; e_exmem = N; e_memwb = N;
    if (stalling()) begin
      e_pc = R;
      e_ifid = R;
      if (m_mode == 0 && !(mem_req && !mem_ack)) begin
        e_idex = B;
      end else begin
        e_idex = R;
        e_memwb = B;
        e_exmem = (m_mode == 1 && m_wait == TMO) ? N : R;
      end
    end
    e_ign = (e_ifid == N && m_prev_retry) ? 1 : 0;
    check("pc_hazard", int'(hz.pc_hazard), e_pc);
    check("if_id_hazard", int'(hz.if_id_hazard), e_ifid);
    check("id_ex_hazard", int'(hz.id_ex_hazard), e_idex);
    check("ex_mem_hazard", int'(hz.ex_mem_hazard), e_exmem);
    check("mem_wb_hazard", int'(hz.mem_wb_hazard), e_memwb);
    check("ignore_no_op", int'(hz.ignore_no_op), e_ign);
    check("paused", int'(paused), (!rst && m_mode == 2) ? 1 : 0);
    check("mem_timeout", int'(mem_timeout), int'(m_tmo));
    check("stall_count", int'(stall_count), m_stalls);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_no_op = 0; id_rs = 0; id_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    ex_no_op = 0; ex_mem_read = 0; ex_dest = 0;
    mem_req = 0; mem_ack = 0; pause_req = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    idle();
    tick(); tick(); #2;
    check("rst_pc", int'(hz.pc_hazard), N);
    check("rst_stall", int'(stall_count), 0);
    check("rst_paused", int'(paused), 0);
    check("rst_ign", int'(hz.ignore_no_op), 0);
    tick();
    rst = 0;

    ex_mem_read = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    #2;
    check("lu_pc", int'(hz.pc_hazard), R);
    check("lu_ifid", int'(hz.if_id_hazard), R);
    check("lu_idex", int'(hz.id_ex_hazard), B);
    check("lu_exmem", int'(hz.ex_mem_hazard), N);
    tick(); idle(); #2;
    check("lu_after_pc", int'(hz.pc_hazard), N);
    check("lu_after_ign", int'(hz.ignore_no_op), 1);
    check("lu_stall", int'(stall_count), 1);
    tick(); #2;
    check("lu_ign_clear", int'(hz.ignore_no_op), 0);

    ex_mem_read = 1; ex_dest = 0; id_rs = 0; id_uses_rs = 1;
    #2 check("r0_nostall", int'(hz.pc_hazard), N);
    ex_dest = 5; id_rs = 5; id_uses_rs = 0;
    #1 check("unused_nostall", int'(hz.pc_hazard), N);
    id_rt = 5; id_uses_rt = 1;
    #1 check("rt_idex", int'(hz.id_ex_hazard), B);
    ex_no_op = 1;
    #1 check("exbubble_nostall", int'(hz.pc_hazard), N);
    tick();

    do_reset();
    mem_req = 1;
    repeat (3) begin
      #2;
      check("mw_pc", int'(hz.pc_hazard), R);
      check("mw_memwb", int'(hz.mem_wb_hazard), B);
      tick();
    end
    mem_ack = 1; #2;
    check("mw_ack_pc", int'(hz.pc_hazard), N);
    check("mw_ack_ign", int'(hz.ignore_no_op), 1);
    tick(); idle(); #2;
    check("mw_stall", int'(stall_count), 3);

    do_reset();
    mem_req = 1;
    repeat (5) begin
      #2 check("to_exmem_hold", int'(hz.ex_mem_hazard), R);
      tick();
    end
    #2;
    check("to_exmem_drop", int'(hz.ex_mem_hazard), N);
    check("to_pc", int'(hz.pc_hazard), R);
    check("to_pulse_pre", int'(mem_timeout), 0);
    tick(); mem_req = 0; #2;
    check("to_pulse", int'(mem_timeout), 1);
    check("to_run_pc", int'(hz.pc_hazard), N);
    tick(); #2;
    check("to_pulse_once", int'(mem_timeout), 0);

    do_reset();
    mem_req = 1;
    tick(); tick();
    pause_req = 1;
    tick();
    mem_ack = 1; #2;
    check("pw_ack_pc", int'(hz.pc_hazard), N);
    tick(); mem_req = 0; mem_ack = 0; #2;
    check("pw_paused", int'(paused), 1);
    check("pw_pc", int'(hz.pc_hazard), R);
    check("pw_memwb", int'(hz.mem_wb_hazard), B);
    pause_req = 0; #2;
    check("pw_paused_hold", int'(paused), 1);
    tick(); #2;
    check("pw_run", int'(paused), 0);
    check("pw_ign", int'(hz.ignore_no_op), 1);

    pause_req = 1;
    tick(); #2;
    check("rp_paused", int'(paused), 1);
    rst = 1; #1;
    check("rp_async_paused", int'(paused), 0);
    check("rp_async_pc", int'(hz.pc_hazard), N);
    check("rp_async_stall", int'(stall_count), 0);
    tick();
    rst = 0; pause_req = 0;

    pause_req = 1;
    repeat (70) tick();
    #2 check("sat_stall", int'(stall_count), SAT);
    pause_req = 0;
    tick();

    repeat (3000) begin
      id_no_op = ($urandom_range(0, 7) == 0);
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_no_op = ($urandom_range(0, 7) == 0);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_dest = 5'($urandom_range(0, 3));
      mem_req = ($urandom_range(0, 3) == 0);
      mem_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    idle();
    rst = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
